slow_pkt_reader: RTL
====================

Name: slow_pkt_reader

Overview:
- Read-side consumer of the slow FIFO that carries 16-word event packets: PID, {status, event count}, {X, Y}, {S, 0}, four channel powers, max values, calibration results and drift gains.
- Runs in the MB bus clock domain.
- Pulls complete packets out of the FIFO and validates the PID word, hunting word-by-word to resync when the PID does not match.
- Presents the fields as held registers with a one-cycle valid pulse, and tracks framing errors and lost events from the event-counter sequence.

Parameters:
- SFIFO_WIDTH, 32, FIFO word width.
- DATA_WIDTH, 16, width of the X/Y/S/status/count fields.
- PKT_LEN, 16, words per packet including the PID.
- PID, 32'h4142504d, packet header word ("ABPM").
- CNT_WIDTH, 6, width of the FIFO read-count input.

Ports:
- clk  in  1  MB bus clock, all logic rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_dout  in  SFIFO_WIDTH  FIFO read data; standard (non-FWFT) FIFO, valid the cycle after fifo_rd.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_count  in  CNT_WIDTH  FIFO read data count.
- fifo_rd  out  1  FIFO read enable.
- clr_stats  in  1  synchronous clear of err_cnt, lost_cnt and the sequence history.
- pkt_valid  out  1  one-cycle pulse when all output fields have been updated.
- status  out  DATA_WIDTH  word1[31:16].
- evt_cnt  out  DATA_WIDTH  word1[15:0].
- x_pos, y_pos  out  DATA_WIDTH each  word2[31:16], word2[15:0].
- s_sum  out  DATA_WIDTH  word3[31:16]; word3[15:0] is ignored.
- pwr_a, pwr_b, pwr_c, pwr_d  out  SFIFO_WIDTH each  words 4–7.
- max_ab, max_cd  out  SFIFO_WIDTH each  words 8–9.
- xy_cal  out  SFIFO_WIDTH  word10; word11 is reserved and ignored.
- pwr_a_cal, pwr_b_cal, drift_a, drift_b  out  SFIFO_WIDTH each  words 12–15.
- err_cnt  out  16  framing errors, saturating.
- lost_cnt  out  16  missing events inferred from evt_cnt gaps, saturating.

Behaviour:
- **Reset (async):** all outputs 0, FSM in IDLE, seq_valid=0.
- **Read guard:** fifo_rd is never asserted while fifo_empty=1; this overrides every state.
- **FSM states:**
  - IDLE: if fifo_rd_count>=1 and !fifo_empty → HDR_RD.
  - HDR_RD: assert fifo_rd for exactly one cycle → HDR_CHK.
  - HDR_CHK: compare fifo_dout with PID.
    - Match: clear in_hunt → BODY_WAIT.
    - Mismatch: if in_hunt=0, set in_hunt and increment err_cnt; otherwise no increment. → IDLE.
    - Result: one error is counted per resync episode, regardless of how many junk words are discarded.
  - BODY_WAIT: wait until fifo_rd_count>=PKT_LEN-1 → BODY.
  - BODY: assert fifo_rd on PKT_LEN-1 consecutive cycles; a 4-bit index counts the words.
    - Each returned word (one cycle after its read) goes into a shadow register at index 1..15.
    - The PID is not rechecked inside a body.
  - COMMIT: fires one cycle after the 15th word returns. Copy shadow to outputs, pulse pkt_valid, update the sequence check → IDLE.
- **Latency:** pkt_valid is asserted 19 cycles after the HDR_RD cycle when the FIFO already holds ≥16 words.
- **Output hold:** outputs change only at COMMIT, so a partially read packet never appears on the outputs.
- **Sequence check at COMMIT:**
  - If seq_valid=1 and new != prev+1 (mod 2^16), add (new - prev - 1) mod 2^16 to lost_cnt, saturating at 16'hFFFF.
  - prev is updated to new; seq_valid is set to 1.
  - A count of 0 following 0xFFFF is not a gap.
  - Reset or clr_stats clears seq_valid, so no gap is counted on the first packet after either.
- **clr_stats:**
  - If clr_stats coincides with COMMIT, the clear wins for the counters.
  - prev and seq_valid are still loaded from that packet.
- **Saturation:** err_cnt also saturates at 16'hFFFF.
- **Reset mid-body:** the partially read packet is abandoned. Remaining words are later rejected by the header check and counted as a single error episode.

Decomposition:
- Package slow_pkt_pkg holds:
  - PID and PKT_LEN;
  - word index constants: W_STAT=1, W_XY=2, W_S=3, W_PWR_A..D=4..7, W_MAX_AB=8, W_MAX_CD=9, W_XY_CAL=10, W_RSVD=11, W_PA_CAL=12, W_PB_CAL=13, W_DRIFT_A=14, W_DRIFT_B=15;
  - the FSM state enum.
- One sub-module, evt_seq_check: prev register, gap arithmetic, saturating lost_cnt, clear handling.

Test Plan:
1. Push one packet with PID, word1=32'h0003_0001, words 2..15 = 32'h1000+i; then 19 cycles → one pkt_valid; evt_cnt=1, status=3, x_pos=16'h0000, y_pos=16'h1002, pwr_d=32'h1007, drift_b=32'h100F; err_cnt=0, lost_cnt=0.
2. Back-to-back packets with evt_cnt 5, 6, 9 → three pkt_valid pulses; lost_cnt=2.
3. Push 3 junk words (32'hDEADBEEF), then a valid packet → err_cnt=1 and the packet decodes correctly; fifo_rd never asserted while fifo_empty=1.
4. Stall the FIFO at 10 words after the PID → no pkt_valid and outputs unchanged; push the remaining 5 words → pkt_valid, correct fields.
5. evt_cnt 16'hFFFF then 16'h0000 → lost_cnt stays 0; then evt_cnt 16'h0005 with clr_stats pulsed between packets → lost_cnt=0.
6. Assert rst during BODY at word 7 → all outputs 0 immediately; after release, the remaining 9 words plus a good packet → err_cnt=1 and the good packet decodes.

Source files
------------

// File: rtl/slow_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slow_pkt_pkg
// Purpose  : Shared constants and types for the slow-FIFO packet reader.
//            Holds the packet header word, packet length, the index of each
//            field inside a packet and the reader FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package slow_pkt_pkg;

  // Header word "ABPM" and words per packet (header included)
  localparam logic [31:0] SLOW_PID     = 32'h4142504d;
  localparam int          SLOW_PKT_LEN = 16;

  // Word positions inside a packet (word 0 is the PID)
  localparam logic [3:0] W_STAT    = 4'd1;
  localparam logic [3:0] W_XY      = 4'd2;
  localparam logic [3:0] W_S       = 4'd3;
  localparam logic [3:0] W_PWR_A   = 4'd4;
  localparam logic [3:0] W_PWR_B   = 4'd5;
  localparam logic [3:0] W_PWR_C   = 4'd6;
  localparam logic [3:0] W_PWR_D   = 4'd7;
  localparam logic [3:0] W_MAX_AB  = 4'd8;
  localparam logic [3:0] W_MAX_CD  = 4'd9;
  localparam logic [3:0] W_XY_CAL  = 4'd10;
  localparam logic [3:0] W_RSVD    = 4'd11;
  localparam logic [3:0] W_PA_CAL  = 4'd12;
  localparam logic [3:0] W_PB_CAL  = 4'd13;
  localparam logic [3:0] W_DRIFT_A = 4'd14;
  localparam logic [3:0] W_DRIFT_B = 4'd15;

  // Reader FSM. S_DRAIN is the cycle in which the last body word returns.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR_RD    = 3'd1,
    S_HDR_CHK   = 3'd2,
    S_BODY_WAIT = 3'd3,
    S_BODY      = 3'd4,
    S_DRAIN     = 3'd5,
    S_COMMIT    = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/evt_seq_check.sv
`default_nettype none
// ============================================================================
// Module   : evt_seq_check
// Purpose  : Tracks the event-counter sequence across committed packets and
//            accumulates the number of missing events in a saturating count.
// Ports    : clk      - clock
//            rst      - asynchronous active-high reset
//            clr      - synchronous clear of lost_cnt and sequence history
//            commit   - a new packet's counter is on new_cnt this cycle
//            new_cnt  - event counter of the committed packet
//            lost_cnt - saturating count of missing events
// Revision : 1.0 - initial release
// ============================================================================
module evt_seq_check
  import slow_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOST_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] new_cnt,
  output logic [LOST_WIDTH-1:0] lost_cnt
);

  localparam int SUM_W = ((DATA_WIDTH > LOST_WIDTH) ? DATA_WIDTH : LOST_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] c_one = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_seq_valid;

  logic [DATA_WIDTH-1:0] w_gap;
  logic                  w_gap_hit;
  logic [SUM_W-1:0]      w_sum;
  logic [LOST_WIDTH-1:0] w_lost_next;

  // Modular arithmetic: a wrap from all-ones to zero is a step of one
  assign w_gap       = new_cnt - r_prev - c_one;
  assign w_gap_hit   = r_seq_valid && (new_cnt != (r_prev + c_one));
  assign w_sum       = SUM_W'(lost_cnt) + SUM_W'(w_gap);
  assign w_lost_next = (|w_sum[SUM_W-1:LOST_WIDTH]) ? '1 : w_sum[LOST_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= '0;
      r_seq_valid <= 1'b0;
      lost_cnt    <= '0;
    end else begin
      // History always follows a committed packet, even when clr coincides
      if (commit) begin
        r_prev      <= new_cnt;
        r_seq_valid <= 1'b1;
      end else if (clr) begin
        r_seq_valid <= 1'b0;
      end

      if (clr) begin
        lost_cnt <= '0;
      end else if (commit && w_gap_hit) begin
        lost_cnt <= w_lost_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/slow_pkt_reader.sv
`default_nettype none
// ============================================================================
// Module   : slow_pkt_reader
// Purpose  : Pulls 16-word event packets out of a standard (non-FWFT) FIFO,
//            validates the PID header (hunting word by word to resync), and
//            presents the fields as held registers with a one-cycle valid.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            fifo_dout/empty/rd_count, fifo_rd - FIFO read side
//            clr_stats         - synchronous clear of err/lost counters
//            pkt_valid         - one-cycle pulse when fields are updated
//            status..drift_b   - decoded packet fields
//            err_cnt, lost_cnt - saturating framing / lost-event counters
// Revision : 1.0 - initial release
// ============================================================================
module slow_pkt_reader
  import slow_pkt_pkg::*;
#(
  parameter int                     SFIFO_WIDTH = 32,
  parameter int                     DATA_WIDTH  = 16,
  parameter int                     PKT_LEN     = SLOW_PKT_LEN,
  parameter logic [SFIFO_WIDTH-1:0] PID         = SLOW_PID,
  parameter int                     CNT_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SFIFO_WIDTH-1:0] fifo_dout,
  input  logic                   fifo_empty,
  input  logic [CNT_WIDTH-1:0]   fifo_rd_count,
  output logic                   fifo_rd,
  input  logic                   clr_stats,
  output logic                   pkt_valid,
  output logic [DATA_WIDTH-1:0]  status,
  output logic [DATA_WIDTH-1:0]  evt_cnt,
  output logic [DATA_WIDTH-1:0]  x_pos,
  output logic [DATA_WIDTH-1:0]  y_pos,
  output logic [DATA_WIDTH-1:0]  s_sum,
  output logic [SFIFO_WIDTH-1:0] pwr_a,
  output logic [SFIFO_WIDTH-1:0] pwr_b,
  output logic [SFIFO_WIDTH-1:0] pwr_c,
  output logic [SFIFO_WIDTH-1:0] pwr_d,
  output logic [SFIFO_WIDTH-1:0] max_ab,
  output logic [SFIFO_WIDTH-1:0] max_cd,
  output logic [SFIFO_WIDTH-1:0] xy_cal,
  output logic [SFIFO_WIDTH-1:0] pwr_a_cal,
  output logic [SFIFO_WIDTH-1:0] pwr_b_cal,
  output logic [SFIFO_WIDTH-1:0] drift_a,
  output logic [SFIFO_WIDTH-1:0] drift_b,
  output logic [15:0]            err_cnt,
  output logic [15:0]            lost_cnt
);

  localparam logic [3:0]           c_last_idx = 4'(PKT_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] c_body_cnt = CNT_WIDTH'(PKT_LEN - 1);

  state_t r_state;
  state_t w_next;

  logic [3:0] r_rd_idx;    // body word being requested
  logic [3:0] r_cap_idx;   // body word currently on fifo_dout
  logic       r_rd_d;      // a read was issued last cycle
  logic       r_in_hunt;
  logic       w_rd_req;
  logic       w_pid_ok;

  logic [DATA_WIDTH-1:0]  r_sh_status, r_sh_evt, r_sh_x, r_sh_y, r_sh_s;
  logic [SFIFO_WIDTH-1:0] r_sh_pwr_a, r_sh_pwr_b, r_sh_pwr_c, r_sh_pwr_d;
  logic [SFIFO_WIDTH-1:0] r_sh_max_ab, r_sh_max_cd, r_sh_xy_cal;
  logic [SFIFO_WIDTH-1:0] r_sh_pa_cal, r_sh_pb_cal, r_sh_drift_a;

  assign w_pid_ok = (fifo_dout == PID);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if ((fifo_rd_count != '0) && !fifo_empty) w_next = S_HDR_RD;
      // Only move on once the header read has actually been issued
      S_HDR_RD:    if (fifo_rd) w_next = S_HDR_CHK;
      S_HDR_CHK:   w_next = w_pid_ok ? S_BODY_WAIT : S_IDLE;
      S_BODY_WAIT: if (fifo_rd_count >= c_body_cnt) w_next = S_BODY;
      S_BODY:      if (fifo_rd && (r_rd_idx == c_last_idx)) w_next = S_DRAIN;
      S_DRAIN:     w_next = S_COMMIT;
      S_COMMIT:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    w_rd_req  = (r_state == S_HDR_RD) || (r_state == S_BODY);
    // Empty guard overrides every state
    fifo_rd   = w_rd_req && !fifo_empty;
    pkt_valid = (r_state == S_COMMIT);
  end

  // ------------------------------------------------ indices, hunt, err_cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_idx  <= '0;
      r_cap_idx <= '0;
      r_rd_d    <= 1'b0;
      r_in_hunt <= 1'b0;
      err_cnt   <= '0;
    end else begin
      r_rd_d <= fifo_rd;

      if (r_state == S_BODY_WAIT) begin
        r_rd_idx  <= 4'd1;
        r_cap_idx <= 4'd1;
      end else begin
        if ((r_state == S_BODY) && fifo_rd) r_rd_idx <= r_rd_idx + 4'd1;
        if (r_rd_d && ((r_state == S_BODY) || (r_state == S_DRAIN)))
          r_cap_idx <= r_cap_idx + 4'd1;
      end

      // One error per resync episode: only the first bad header counts
      if (r_state == S_HDR_CHK) begin
        if (w_pid_ok)        r_in_hunt <= 1'b0;
        else if (!r_in_hunt) r_in_hunt <= 1'b1;
      end

      if (clr_stats)
        err_cnt <= '0;
      else if ((r_state == S_HDR_CHK) && !w_pid_ok && !r_in_hunt && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end

  // ------------------------------------------------------------ shadow capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_status  <= '0; r_sh_evt    <= '0;
      r_sh_x       <= '0; r_sh_y      <= '0; r_sh_s <= '0;
      r_sh_pwr_a   <= '0; r_sh_pwr_b  <= '0;
      r_sh_pwr_c   <= '0; r_sh_pwr_d  <= '0;
      r_sh_max_ab  <= '0; r_sh_max_cd <= '0; r_sh_xy_cal <= '0;
      r_sh_pa_cal  <= '0; r_sh_pb_cal <= '0; r_sh_drift_a <= '0;
    end else if (r_rd_d && (r_state == S_BODY)) begin
      case (r_cap_idx)
        W_STAT: begin
          r_sh_status <= fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
          r_sh_evt    <= fifo_dout[DATA_WIDTH-1:0];
        end
        W_XY: begin
          r_sh_x <= fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
          r_sh_y <= fifo_dout[DATA_WIDTH-1:0];
        end
        W_S:       r_sh_s       <= fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
        W_PWR_A:   r_sh_pwr_a   <= fifo_dout;
        W_PWR_B:   r_sh_pwr_b   <= fifo_dout;
        W_PWR_C:   r_sh_pwr_c   <= fifo_dout;
        W_PWR_D:   r_sh_pwr_d   <= fifo_dout;
        W_MAX_AB:  r_sh_max_ab  <= fifo_dout;
        W_MAX_CD:  r_sh_max_cd  <= fifo_dout;
        W_XY_CAL:  r_sh_xy_cal  <= fifo_dout;
        W_PA_CAL:  r_sh_pa_cal  <= fifo_dout;
        W_PB_CAL:  r_sh_pb_cal  <= fifo_dout;
        W_DRIFT_A: r_sh_drift_a <= fifo_dout;
        default: ;  // W_RSVD is discarded
      endcase
    end
  end

  // ---------------------------------------------------------- output registers
  // Loaded on the edge into COMMIT so the fields are valid together with
  // pkt_valid. The final word is still on fifo_dout during DRAIN and is taken
  // from there directly rather than through a shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status    <= '0; evt_cnt   <= '0;
      x_pos     <= '0; y_pos     <= '0; s_sum <= '0;
      pwr_a     <= '0; pwr_b     <= '0; pwr_c <= '0; pwr_d <= '0;
      max_ab    <= '0; max_cd    <= '0; xy_cal <= '0;
      pwr_a_cal <= '0; pwr_b_cal <= '0;
      drift_a   <= '0; drift_b   <= '0;
    end else if (r_state == S_DRAIN) begin
      status    <= r_sh_status;  evt_cnt   <= r_sh_evt;
      x_pos     <= r_sh_x;       y_pos     <= r_sh_y;      s_sum <= r_sh_s;
      pwr_a     <= r_sh_pwr_a;   pwr_b     <= r_sh_pwr_b;
      pwr_c     <= r_sh_pwr_c;   pwr_d     <= r_sh_pwr_d;
      max_ab    <= r_sh_max_ab;  max_cd    <= r_sh_max_cd;
      xy_cal    <= r_sh_xy_cal;
      pwr_a_cal <= r_sh_pa_cal;  pwr_b_cal <= r_sh_pb_cal;
      drift_a   <= r_sh_drift_a; drift_b   <= fifo_dout;
    end
  end

  // ---------------------------------------------------------- sequence check
  evt_seq_check #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOST_WIDTH (16)
  ) u_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_stats),
    .commit   (r_state == S_COMMIT),
    .new_cnt  (evt_cnt),
    .lost_cnt (lost_cnt)
  );

endmodule
`default_nettype wire
